// File: rtl/tex_mem_responder_if.sv
// rtl/tex_mem_responder_if.sv - multi-channel word-read bus between texture scheduler and memory responder
interface tex_mem_responder_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
);
  logic [NUM_REQS-1:0]                   req_valid;
  logic [NUM_REQS-1:0]                   req_rw;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_REQS-1:0][DATA_WIDTH/8-1:0] req_byteen;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]    req_tag;
  logic [NUM_REQS-1:0]                   req_ready;
  logic [NUM_REQS-1:0]                   rsp_valid;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]   rsp_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]    rsp_tag;
  logic [NUM_REQS-1:0]                   rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/tex_mem_responder.sv
// rtl/tex_mem_responder.sv - credit-bounded multi-channel texel store with fixed-latency tagged read responses
module tex_mem_responder #(
  parameter int NUM_REQS       = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input logic clk,
  input logic reset,
  tex_mem_responder_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_QUEUE_SIZE);

  logic [DATA_WIDTH-1:0] store [2**ADDR_WIDTH];

  logic [NUM_REQS-1:0]                 ready_vec;
  logic [NUM_REQS-1:0]                 valid_vec;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] data_vec;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  tag_vec;

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = valid_vec;
  assign bus.rsp_data  = data_vec;
  assign bus.rsp_tag   = tag_vec;

  // Byte-lane writes applied in ascending channel order, so the highest channel wins each lane
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (bus.req_valid[i] && ready_vec[i] && bus.req_rw[i]) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.req_byteen[i][b]) begin
            store[bus.req_addr[i]][b*8 +: 8] <= bus.req_data[i][b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_ch
    logic [CNT_W-1:0]      outst;
    logic                  rd_fire;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [TAG_WIDTH-1:0]  push_tag;
    logic [DATA_WIDTH-1:0] fifo_data [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_QUEUE_SIZE];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    assign ready_vec[i] = (outst != FULL_CNT);
    assign rd_fire      = bus.req_valid[i] && ready_vec[i] && !bus.req_rw[i];
    assign valid_vec[i] = (count != '0);
    assign pop          = valid_vec[i] && bus.rsp_ready[i];
    assign data_vec[i]  = fifo_data[rd_ptr];
    assign tag_vec[i]   = fifo_tag[rd_ptr];

    // Credits: reads accepted but not yet popped; writes never consume one
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        outst <= '0;
      end else if (rd_fire && !pop) begin
        outst <= outst + CNT_W'(1);
      end else if (!rd_fire && pop) begin
        outst <= outst - CNT_W'(1);
      end
    end

    if (LATENCY == 1) begin : g_direct
      assign push      = rd_fire;
      assign push_data = store[bus.req_addr[i]];
      assign push_tag  = bus.req_tag[i];
    end else begin : g_pipe
      logic [LATENCY-2:0]    pv;
      logic [DATA_WIDTH-1:0] pd [LATENCY-1];
      logic [TAG_WIDTH-1:0]  pt [LATENCY-1];

      // Stage 0 samples the store before this edge's writes land, giving read-before-write
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pv <= '0;
          for (int k = 0; k < LATENCY-1; k++) begin
            pd[k] <= '0;
            pt[k] <= '0;
          end
        end else begin
          pv[0] <= rd_fire;
          pd[0] <= store[bus.req_addr[i]];
          pt[0] <= bus.req_tag[i];
          for (int k = 1; k < LATENCY-1; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
            pt[k] <= pt[k-1];
          end
        end
      end

      assign push      = pv[LATENCY-2];
      assign push_data = pd[LATENCY-2];
      assign push_tag  = pt[LATENCY-2];
    end

    // Response FIFO; entries are cleared on reset so the head never shows X
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int q = 0; q < RSP_QUEUE_SIZE; q++) begin
          fifo_data[q] <= '0;
          fifo_tag[q]  <= '0;
        end
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= push_data;
          fifo_tag[wr_ptr]  <= push_tag;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (!push && pop) begin
          count <= count - CNT_W'(1);
        end
      end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop && count == FULL_CNT));
  end
endmodule

// File: tb/tb_tex_mem_responder.sv
// tb/tb_tex_mem_responder.sv - directed self-checking bench for tex_mem_responder
module tb_tex_mem_responder;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc;

  always #5 clk = ~clk;

  tex_mem_responder_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  tex_mem_responder #(
    .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .LATENCY(2), .RSP_QUEUE_SIZE(4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid  = '0;
    bus.req_rw     = '0;
    bus.req_addr   = '0;
    bus.req_byteen = '0;
    bus.req_data   = '0;
    bus.req_tag    = '0;
    bus.rsp_ready  = '1;
  endtask

  task automatic wr(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic [3:0] be);
    bus.req_valid[ch]  = 1'b1;
    bus.req_rw[ch]     = 1'b1;
    bus.req_addr[ch]   = addr;
    bus.req_data[ch]   = data;
    bus.req_byteen[ch] = be;
    tick();
    bus.req_valid[ch]  = 1'b0;
    bus.req_rw[ch]     = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    bus.req_valid[ch] = 1'b1;
    bus.req_rw[ch]    = 1'b0;
    bus.req_addr[ch]  = addr;
    bus.req_tag[ch]   = tag;
    tick();
    bus.req_valid[ch] = 1'b0;
  endtask

  initial begin
    idle();
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'hF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_data_known", 32'(!$isunknown(bus.rsp_data)), 32'h1);
    check("post_rst_valid", 32'(bus.rsp_valid), 32'h0);

    // write/read round trip on ch0
    wr(0, 10'h010, 32'hDEADBEEF, 4'hF);
    check("rt_ready", 32'(bus.req_ready[0]), 32'h1);
    rd(0, 10'h010, 8'h5A);
    check("rt_lat1_valid", 32'(bus.rsp_valid[0]), 32'h0);
    tick();
    check("rt_valid", 32'(bus.rsp_valid[0]), 32'h1);
    check("rt_data", bus.rsp_data[0], 32'hDEADBEEF);
    check("rt_tag", 32'(bus.rsp_tag[0]), 32'h5A);
    tick();
    check("rt_popped", 32'(bus.rsp_valid[0]), 32'h0);

    // byte enables
    wr(0, 10'h020, 32'h11223344, 4'hF);
    wr(0, 10'h020, 32'hAABBCCDD, 4'b0101);
    rd(0, 10'h020, 8'h01);
    tick();
    check("be_valid", 32'(bus.rsp_valid[0]), 32'h1);
    check("be_data", bus.rsp_data[0], 32'h11BB33DD);
    tick();

    // credit backpressure on ch1
    bus.rsp_ready[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_rw[1]    = 1'b0;
    bus.req_addr[1]  = 10'h010;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.req_tag[1] = 8'(acc);
      check($sformatf("bp_ready_c%0d", c), 32'(bus.req_ready[1]), (c < 4) ? 32'h1 : 32'h0);
      if (bus.req_ready[1]) acc++;
      tick();
    end
    bus.req_valid[1] = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    tick();
    check("bp_full_valid", 32'(bus.rsp_valid[1]), 32'h1);
    check("bp_full_ready", 32'(bus.req_ready[1]), 32'h0);
    check("bp_tag0", 32'(bus.rsp_tag[1]), 32'h0);
    bus.rsp_ready[1] = 1'b1;
    tick();
    check("bp_ready_back", 32'(bus.req_ready[1]), 32'h1);
    check("bp_tag1", 32'(bus.rsp_tag[1]), 32'h1);
    tick();
    check("bp_tag2", 32'(bus.rsp_tag[1]), 32'h2);
    tick();
    check("bp_tag3", 32'(bus.rsp_tag[1]), 32'h3);
    tick();
    check("bp_drained", 32'(bus.rsp_valid[1]), 32'h0);

    // same-cycle read/write collision
    wr(0, 10'h030, 32'h0, 4'hF);
    bus.req_valid[0] = 1'b1;  bus.req_rw[0] = 1'b0;  bus.req_addr[0] = 10'h030;  bus.req_tag[0] = 8'h07;
    bus.req_valid[2] = 1'b1;  bus.req_rw[2] = 1'b1;  bus.req_addr[2] = 10'h030;
    bus.req_data[2] = 32'h00001234;  bus.req_byteen[2] = 4'hF;
    tick();
    bus.req_valid[2] = 1'b0;  bus.req_rw[2] = 1'b0;
    bus.req_tag[0] = 8'h08;
    tick();
    bus.req_valid[0] = 1'b0;
    check("col_old_data", bus.rsp_data[0], 32'h0);
    check("col_old_tag", 32'(bus.rsp_tag[0]), 32'h07);
    tick();
    check("col_new_data", bus.rsp_data[0], 32'h00001234);
    check("col_new_tag", 32'(bus.rsp_tag[0]), 32'h08);
    tick();
    bus.req_valid[1] = 1'b1;  bus.req_rw[1] = 1'b1;  bus.req_addr[1] = 10'h030;
    bus.req_data[1] = 32'h11111111;  bus.req_byteen[1] = 4'hF;
    bus.req_valid[3] = 1'b1;  bus.req_rw[3] = 1'b1;  bus.req_addr[3] = 10'h030;
    bus.req_data[3] = 32'h33333333;  bus.req_byteen[3] = 4'hF;
    tick();
    bus.req_valid[1] = 1'b0;  bus.req_rw[1] = 1'b0;
    bus.req_valid[3] = 1'b0;  bus.req_rw[3] = 1'b0;
    rd(0, 10'h030, 8'h09);
    tick();
    check("ww_data", bus.rsp_data[0], 32'h33333333);
    tick();

    // simultaneous push/pop around full credit on ch2
    bus.rsp_ready[2] = 1'b0;
    bus.req_valid[2] = 1'b1;  bus.req_rw[2] = 1'b0;  bus.req_addr[2] = 10'h010;
    for (int k = 0; k < 4; k++) begin
      bus.req_tag[2] = 8'(10 + k);
      tick();
    end
    bus.req_valid[2] = 1'b0;
    tick();
    tick();
    check("pp_full_ready", 32'(bus.req_ready[2]), 32'h0);
    check("pp_tag10", 32'(bus.rsp_tag[2]), 32'd10);
    bus.rsp_ready[2] = 1'b1;
    bus.req_valid[2] = 1'b1;
    bus.req_tag[2]   = 8'd14;
    tick();
    check("pp_ready_c1", 32'(bus.req_ready[2]), 32'h1);
    check("pp_tag11", 32'(bus.rsp_tag[2]), 32'd11);
    tick();
    bus.req_valid[2] = 1'b0;
    check("pp_ready_c2", 32'(bus.req_ready[2]), 32'h1);
    check("pp_tag12", 32'(bus.rsp_tag[2]), 32'd12);
    tick();
    check("pp_tag13", 32'(bus.rsp_tag[2]), 32'd13);
    tick();
    check("pp_tag14", 32'(bus.rsp_tag[2]), 32'd14);
    check("pp_data14", bus.rsp_data[2], 32'hDEADBEEF);
    tick();
    check("pp_drained", 32'(bus.rsp_valid[2]), 32'h0);

    // reset mid-stream with three reads queued on ch0
    bus.rsp_ready[0] = 1'b0;
    bus.req_valid[0] = 1'b1;  bus.req_rw[0] = 1'b0;  bus.req_addr[0] = 10'h010;
    for (int k = 0; k < 3; k++) begin
      bus.req_tag[0] = 8'(20 + k);
      tick();
    end
    bus.req_valid[0] = 1'b0;
    tick();
    tick();
    check("mr_pending", 32'(bus.rsp_valid[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(bus.rsp_valid), 32'h0);
    check("mr_ready", 32'(bus.req_ready), 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready[0] = 1'b1;
    #1;
    check("mr_after_valid", 32'(bus.rsp_valid), 32'h0);
    rd(0, 10'h010, 8'd23);
    tick();
    check("mr_new_valid", 32'(bus.rsp_valid[0]), 32'h1);
    check("mr_new_tag", 32'(bus.rsp_tag[0]), 32'd23);
    check("mr_new_data", bus.rsp_data[0], 32'hDEADBEEF);
    tick();
    check("mr_one_rsp", 32'(bus.rsp_valid[0]), 32'h0);
    tick();
    check("mr_still_empty", 32'(bus.rsp_valid[0]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
